mul_ctrl: RTL and testbench

MUL_CTRL -- requirements
Module: mul_ctrl

---
 rtl/mul_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mul_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_ctrl.sv
// mul_ctrl: control sequencer for the M-extension multiply unit.
//
// It accepts one multiply request from the EX stage and decodes funct3 into
// the multiplier's word select and operand signedness. It holds the
// registered operands and the enable for the duration of the operation,
// then returns the result as a one-cycle writeback strobe. A flush, a reset
// or a multiplier that never answers aborts the operation without any
// writeback; the timeout case also raises a sticky error flag.
//
// Ports
//   clk, rst_n              clock; synchronous active-low reset
//   req_valid/req_ready     request handshake from the EX stage
//   req_funct3              0=MUL 1=MULH 2=MULHSU 3=MULHU
//   req_rs1, req_rs2, req_rd  source operands and destination register
//   flush                   pipeline flush; aborts any operation
//   stall_req               freeze upstream pipeline
//   ex_is_mul_inst          multiplier enable (registered, high exactly in BUSY)
//   ex_word_sel             1 selects product bits 63:32, 0 bits 31:0
//   ex_sign_extend          00 unsigned*unsigned, 01 signed*signed,
//                           10 signed rs1 * unsigned rs2
//   m1, m2                  registered multiplier operands
//   mul_done, mul_res       multiplier result strobe and value
//   wb_valid, wb_rd, wb_data  one-cycle writeback; rd/data hold otherwise
//   timeout_err             sticky, cleared only by reset
//   dbg_state               current FSM state (00 IDLE, 01 BUSY, 10 DONE)
//
// Handshake: a request transfers on a rising edge where
// req_valid & req_ready & ~flush is high. req_ready depends only on the FSM
// state, never on req_valid. A flush in the same cycle blocks the transfer.
module mul_ctrl #(
  parameter int TIMEOUT = 8,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [1:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            req_ready,
  output logic            stall_req,
  output logic            ex_is_mul_inst,
  output logic            ex_word_sel,
  output logic [XLEN-1:0] m1,
  output logic [XLEN-1:0] m2,
  output logic [1:0]      ex_sign_extend,
  input  logic            mul_done,
  input  logic [XLEN-1:0] mul_res,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            timeout_err,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic       WORD_LOW  = 1'b0;
  localparam logic       WORD_HIGH = 1'b1;

  localparam logic [1:0] SE_UU = 2'b00;
  localparam logic [1:0] SE_SS = 2'b01;
  localparam logic [1:0] SE_US = 2'b10;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [CW-1:0] cnt_q;
  logic [4:0]    rd_q;
  logic          accept;
  logic          timeout_hit;
  logic          result_hit;
  logic          dec_word_sel;
  logic [1:0]    dec_sign;

  assign req_ready = (state_q != S_BUSY);
  assign accept    = req_valid & req_ready & ~flush;
  assign stall_req = (state_q == S_BUSY) | (req_valid & ~flush);
  assign dbg_state = state_q;

  always_comb begin
    dec_word_sel = WORD_HIGH;
    dec_sign     = SE_SS;
    case (req_funct3)
      2'd0: begin dec_word_sel = WORD_LOW;  dec_sign = SE_SS; end
      2'd1: begin dec_word_sel = WORD_HIGH; dec_sign = SE_SS; end
      2'd2: begin dec_word_sel = WORD_HIGH; dec_sign = SE_US; end
      default: begin dec_word_sel = WORD_HIGH; dec_sign = SE_UU; end
    endcase
  end

  // Flush beats a simultaneous mul_done; mul_done beats a simultaneous
  // timeout, so a result arriving in the last allowed cycle is still taken.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    result_hit  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_BUSY;
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (mul_done) begin
          state_d    = S_DONE;
          result_hit = 1'b1;
        end else if (cnt_q + CW'(1) == CW'(TIMEOUT)) begin
          state_d     = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_DONE: state_d = accept ? S_BUSY : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      rd_q           <= '0;
      ex_is_mul_inst <= 1'b0;
      ex_word_sel    <= WORD_LOW;
      ex_sign_extend <= SE_UU;
      m1             <= '0;
      m2             <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ex_is_mul_inst <= (state_d == S_BUSY);
      wb_valid       <= result_hit;
      timeout_err    <= timeout_err | timeout_hit;

      // Counter holds the number of BUSY cycles already completed.
      if (accept) begin
        cnt_q          <= '0;
        rd_q           <= req_rd;
        m1             <= req_rs1;
        m2             <= req_rs2;
        ex_word_sel    <= dec_word_sel;
        ex_sign_extend <= dec_sign;
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (result_hit) begin
        wb_data <= mul_res;
        wb_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural multiplier that answers in
// the fourth enabled cycle, a writeback scoreboard and a final report.
module tb_mul_ctrl;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
  localparam logic [1:0] SE_UU  = 2'b00;
  localparam logic [1:0] SE_SS  = 2'b01;
  localparam logic [1:0] SE_US  = 2'b10;
  localparam logic       LOW    = 1'b0;
  localparam logic       HIGH   = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        req_ready, stall_req, ex_is_mul_inst, ex_word_sel;
  logic [31:0] m1, m2;
  logic [1:0]  ex_sign_extend;
  logic        mul_done;
  logic [31:0] mul_res;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  mul_ctrl #(.TIMEOUT(8), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
    .req_ready(req_ready), .stall_req(stall_req), .ex_is_mul_inst(ex_is_mul_inst),
    .ex_word_sel(ex_word_sel), .m1(m1), .m2(m2), .ex_sign_extend(ex_sign_extend),
    .mul_done(mul_done), .mul_res(mul_res), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- multiplier model ----------------
  logic mdl_en    = 1'b1;
  logic mdl_force = 1'b0;
  int   mdl_cnt   = 0;

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] se, input logic ws);
    logic signed [65:0] ea, eb, p;
    ea = (se == SE_UU) ? $signed({34'b0, a}) : $signed({{34{a[31]}}, a});
    eb = (se == SE_SS) ? $signed({{34{b[31]}}, b}) : $signed({34'b0, b});
    p  = ea * eb;
    return ws ? p[63:32] : p[31:0];
  endfunction

  always @(posedge clk) mdl_cnt <= ex_is_mul_inst ? mdl_cnt + 1 : 0;

  assign mul_done = mdl_force | (mdl_en & ex_is_mul_inst & (mdl_cnt == 3));
  assign mul_res  = model_mul(m1, m2, ex_sign_extend, ex_word_sel);

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every writeback strobe must match the oldest expected entry.
  always @(negedge clk) begin : wb_monitor
    logic [36:0] e;
    if (wb_valid === 1'b1) begin
      check("wb_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wb_rd_sb", wb_rd, e[36:32]);
        check("wb_data_sb", wb_data, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_rs1    = a;
    req_rs2    = b;
    req_rd     = rd;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ex"}, ex_is_mul_inst, 0);
    check({tag, "_m1"}, m1, 0);
    check({tag, "_m2"}, m2, 0);
    check({tag, "_ws"}, ex_word_sel, 0);
    check({tag, "_se"}, ex_sign_extend, 0);
    check({tag, "_wbv"}, wb_valid, 0);
    check({tag, "_wbrd"}, wb_rd, 0);
    check({tag, "_wbdata"}, wb_data, 0);
    check({tag, "_terr"}, timeout_err, 0);
    check({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  // Full single operation from an idle cycle T; returns in T+6.
  task automatic run_op(input string tag, input logic [1:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data,
                        input logic [1:0] exp_se, input logic exp_ws);
    drive_req(f3, a, b, rd);
    exp_q.push_back({rd, exp_data});
    #1;
    check({tag, "_ready_T"}, req_ready, 1);
    check({tag, "_stall_T"}, stall_req, 1);
    step();
    req_valid = 1'b0;
    check({tag, "_ex_T1"}, ex_is_mul_inst, 1);
    check({tag, "_state_T1"}, dbg_state, S_BUSY);
    check({tag, "_m1"}, m1, a);
    check({tag, "_m2"}, m2, b);
    check({tag, "_se"}, ex_sign_extend, exp_se);
    check({tag, "_ws"}, ex_word_sel, exp_ws);
    for (int i = 2; i <= 4; i++) begin
      step();
      check({tag, "_ex_busy"}, ex_is_mul_inst, 1);
    end
    check({tag, "_ready_busy"}, req_ready, 0);
    check({tag, "_stall_busy"}, stall_req, 1);
    check({tag, "_m1_stable"}, m1, a);
    check({tag, "_se_stable"}, ex_sign_extend, exp_se);
    step();
    check({tag, "_wbv_T5"}, wb_valid, 1);
    check({tag, "_wbdata_T5"}, wb_data, exp_data);
    check({tag, "_wbrd_T5"}, wb_rd, rd);
    check({tag, "_ex_T5"}, ex_is_mul_inst, 0);
    check({tag, "_state_T5"}, dbg_state, S_DONE);
    step();
    check({tag, "_wbv_T6"}, wb_valid, 0);
    check({tag, "_wbdata_hold"}, wb_data, exp_data);
    check({tag, "_wbrd_hold"}, wb_rd, rd);
    check({tag, "_state_T6"}, dbg_state, S_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_funct3 = 2'd0;
    req_rs1 = '0; req_rs2 = '0; req_rd = '0; flush = 1'b0;
    repeat (2) step();
    check_reset_values("por");
    check("por_ready", req_ready, 1);
    check("por_stall", stall_req, 0);
    rst_n = 1'b1;
    step();

    // Basic decode / result cases
    run_op("mul",    2'd0, 32'hFFFF_FFFF, 32'h2,         5'd5, 32'hFFFF_FFFE, SE_SS, LOW);
    run_op("mulhu",  2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, SE_UU, HIGH);
    run_op("mulh",   2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, SE_SS, HIGH);
    run_op("mulhsu", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, SE_US, HIGH);

    // Back-to-back: second request accepted in the DONE cycle
    drive_req(2'd0, 32'd3, 32'd5, 5'd1);
    exp_q.push_back({5'd1, 32'h0000_000F});
    #1;
    step();
    req_valid = 1'b0;
    check("b2b_ex_T1", ex_is_mul_inst, 1);
    for (int i = 2; i <= 4; i++) begin
      step();
      check("b2b_ex_busy", ex_is_mul_inst, 1);
    end
    step();
    check("b2b_wbv_T5", wb_valid, 1);
    check("b2b_wbdata_T5", wb_data, 32'h0000_000F);
    check("b2b_ex_low_T5", ex_is_mul_inst, 0);
    check("b2b_ready_T5", req_ready, 1);
    drive_req(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd2);
    exp_q.push_back({5'd2, 32'h4000_0000});
    #1;
    check("b2b_stall_T5", stall_req, 1);
    step();
    req_valid = 1'b0;
    check("b2b_ex_T6", ex_is_mul_inst, 1);
    check("b2b_m1_T6", m1, 32'h8000_0000);
    check("b2b_ws_T6", ex_word_sel, HIGH);
    check("b2b_se_T6", ex_sign_extend, SE_SS);
    for (int i = 7; i <= 9; i++) begin
      step();
      check("b2b_ex_busy2", ex_is_mul_inst, 1);
    end
    step();
    check("b2b_wbv_T10", wb_valid, 1);
    check("b2b_wbdata_T10", wb_data, 32'h4000_0000);
    check("b2b_wbrd_T10", wb_rd, 2);
    step();

    // Flush in T+2 aborts the operation
    drive_req(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    #1;
    step();
    req_valid = 1'b0;
    step();
    flush = 1'b1;
    #1;
    check("flush_stall_T2", stall_req, 1);
    step();
    flush = 1'b0;
    check("flush_ex_T3", ex_is_mul_inst, 0);
    check("flush_state_T3", dbg_state, S_IDLE);
    check("flush_stall_T3", stall_req, 0);
    repeat (6) step();
    check("flush_no_wb", wb_valid, 0);
    run_op("post_flush", 2'd0, 32'd7, 32'd6, 5'd10, 32'd42, SE_SS, LOW);

    // Flush together with req_valid: not accepted
    drive_req(2'd0, 32'd1, 32'd1, 5'd3);
    flush = 1'b1;
    #1;
    check("flush_req_stall", stall_req, 0);
    step();
    req_valid = 1'b0;
    flush = 1'b0;
    check("flush_req_state", dbg_state, S_IDLE);
    check("flush_req_ex", ex_is_mul_inst, 0);
    step();

    // mul_done outside BUSY is ignored
    mdl_force = 1'b1;
    repeat (3) step();
    check("stray_done_state", dbg_state, S_IDLE);
    check("stray_done_wbv", wb_valid, 0);
    mdl_force = 1'b0;
    step();

    // Timeout: multiplier never answers
    mdl_en = 1'b0;
    drive_req(2'd0, 32'd1, 32'd1, 5'd11);
    #1;
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check("to_ex_busy", ex_is_mul_inst, 1);
      check("to_terr_low", timeout_err, 0);
      step();
    end
    check("to_terr_set", timeout_err, 1);
    check("to_ex_low", ex_is_mul_inst, 0);
    check("to_state", dbg_state, S_IDLE);
    check("to_no_wb", wb_valid, 0);
    mdl_en = 1'b1;
    step();
    run_op("post_to", 2'd3, 32'h0001_0000, 32'h0001_0000, 5'd12, 32'h1, SE_UU, HIGH);
    check("to_sticky", timeout_err, 1);

    // Reset in T+3 of an operation
    drive_req(2'd0, 32'd9, 32'd9, 5'd13);
    #1;
    step();
    req_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    check_reset_values("midrst");
    rst_n = 1'b1;
    repeat (6) step();
    check("midrst_no_wb", wb_valid, 0);
    run_op("post_rst", 2'd3, 32'h8000_0000, 32'd4, 5'd14, 32'h2, SE_UU, HIGH);

    repeat (2) step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
